// File: rtl/cntr_mod_if.sv
// Control and status bundle of the modulo counter: the driving side owns the
// strobes and load value, the counter owns the count and its flags.
interface cntr_mod_if #(
    parameter int WIDTH = 8
) ();
    logic             ce;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             ovf;

    modport master (
        output ce,
        output up,
        output load,
        output din,
        input  out,
        input  tc,
        input  ovf
    );

    modport slave (
        input  ce,
        input  up,
        input  load,
        input  din,
        output out,
        output tc,
        output ovf
    );
endinterface

// File: rtl/cntr_mod.sv
// Parametrised up/down modulo counter with parallel load, wrap or saturate at
// the ends, a combinational terminal count for cascading and a sticky overflow.
module cntr_mod #(
    parameter int WIDTH    = 8,
    parameter int MOD_VAL  = 256,
    parameter bit SATURATE = 1'b0,
    parameter int RST_VAL  = 0
) (
    input  logic       clk,
    input  logic       rst,
    cntr_mod_if.slave  bus
);

    // Modulus held one bit wider so MOD_VAL = 2^WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD_VAL);
    localparam logic [WIDTH:0]   ONE_W = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0]   END_W = MOD_W - ONE_W;
    localparam logic [WIDTH-1:0] END_V = END_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

    logic [WIDTH-1:0] cnt_r;
    logic             ovf_r;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;
    logic             at_end_s;
    logic             at_zero_s;
    logic             tc_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             ovf_nxt_s;

    // Out-of-range load values are pulled down to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] value);
        logic [WIDTH-1:0] result;
        if ({1'b0, value} < MOD_W) begin
            result = value;
        end else begin
            result = END_V;
        end
        return result;
    endfunction

    // Extended-width step arithmetic; the extra bit doubles as end detection.
    always_comb begin
        inc_s     = {1'b0, cnt_r} + ONE_W;
        dec_s     = {1'b0, cnt_r} - ONE_W;
        at_end_s  = (inc_s == MOD_W);
        at_zero_s = dec_s[WIDTH];
    end

    // Terminal count feeds the next stage's enable, so it must not wait a cycle.
    always_comb begin
        if (bus.up) begin
            tc_s = bus.ce & ~bus.load & ~rst & at_end_s;
        end else begin
            tc_s = bus.ce & ~bus.load & ~rst & at_zero_s;
        end
    end

    // Next count and overflow: load beats counting, counting beats holding.
    always_comb begin
        cnt_nxt_s = cnt_r;
        ovf_nxt_s = ovf_r;
        if (bus.load) begin
            cnt_nxt_s = clamp_load(bus.din);
            ovf_nxt_s = 1'b0;
        end else if (bus.ce) begin
            if (bus.up) begin
                if (at_end_s) begin
                    cnt_nxt_s = SATURATE ? cnt_r : ZERO_V;
                    ovf_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = inc_s[WIDTH-1:0];
                    ovf_nxt_s = ovf_r;
                end
            end else begin
                if (at_zero_s) begin
                    cnt_nxt_s = SATURATE ? cnt_r : END_V;
                    ovf_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = dec_s[WIDTH-1:0];
                    ovf_nxt_s = ovf_r;
                end
            end
        end else begin
            cnt_nxt_s = cnt_r;
            ovf_nxt_s = ovf_r;
        end
    end

    // Count and sticky flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= RST_V;
            ovf_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_nxt_s;
        end
    end

    assign bus.out = cnt_r;
    assign bus.ovf = ovf_r;
    assign bus.tc  = tc_s;

endmodule

// File: tb/tb_cntr_mod.sv
// Directed bench for cntr_mod: reset, wrap, saturate, load clamp/priority,
// a two-stage decimal cascade and the full 8-bit binary range.
module tb_cntr_mod;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    cntr_mod_if #(.WIDTH(4)) ia ();
    cntr_mod_if #(.WIDTH(4)) ib ();
    cntr_mod_if #(.WIDTH(4)) ic1 ();
    cntr_mod_if #(.WIDTH(4)) ic2 ();
    cntr_mod_if #(.WIDTH(8)) id ();

    cntr_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0), .RST_VAL(3)) u_a (
        .clk(clk), .rst(rst), .bus(ia));
    cntr_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b1), .RST_VAL(0)) u_b (
        .clk(clk), .rst(rst), .bus(ib));
    cntr_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0), .RST_VAL(0)) u_c1 (
        .clk(clk), .rst(rst), .bus(ic1));
    cntr_mod #(.WIDTH(4), .MOD_VAL(10), .SATURATE(1'b0), .RST_VAL(0)) u_c2 (
        .clk(clk), .rst(rst), .bus(ic2));
    cntr_mod #(.WIDTH(8), .MOD_VAL(256), .SATURATE(1'b0), .RST_VAL(0)) u_d (
        .clk(clk), .rst(rst), .bus(id));

    assign ic2.ce = ic1.tc;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        ia.ce = 1'b1;  ia.up = 1'b1;  ia.load = 1'b0;  ia.din = 4'd0;
        ib.ce = 1'b0;  ib.up = 1'b1;  ib.load = 1'b0;  ib.din = 4'd0;
        ic1.ce = 1'b0; ic1.up = 1'b1; ic1.load = 1'b0; ic1.din = 4'd0;
        ic2.up = 1'b1; ic2.load = 1'b0; ic2.din = 4'd0;
        id.ce = 1'b0;  id.up = 1'b1;  id.load = 1'b0;  id.din = 8'd0;

        // Reset with ce high: tc low during reset, out = RST_VAL afterwards.
        #1;
        chk("rst_tc_pre", 32'(ia.tc), 32'd0);
        tick();
        chk("rst_out", 32'(ia.out), 32'd3);
        chk("rst_ovf", 32'(ia.ovf), 32'd0);
        chk("rst_tc", 32'(ia.tc), 32'd0);
        chk("rst_c_out", 32'({ic2.out, ic1.out}), 32'h00);
        chk("rst_d_out", 32'(id.out), 32'd0);
        rst = 1'b0;
        ia.ce = 1'b0;

        // Up-count wrap from 0 for 12 cycles.
        ia.load = 1'b1; ia.din = 4'd0;
        tick();
        chk("wrap_load0", 32'(ia.out), 32'd0);
        ia.load = 1'b0; ia.ce = 1'b1; ia.up = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk("wrap_tc", 32'(ia.tc), 32'((((i - 1) % 10) == 9) ? 1 : 0));
            tick();
            chk("wrap_out", 32'(ia.out), 32'(i % 10));
            chk("wrap_ovf", 32'(ia.ovf), 32'((i >= 10) ? 1 : 0));
        end
        ia.ce = 1'b0;
        #1;
        chk("hold_tc", 32'(ia.tc), 32'd0);
        tick();
        chk("hold_out", 32'(ia.out), 32'd2);
        chk("hold_ovf", 32'(ia.ovf), 32'd1);

        // Load clamp, then load beating ce at the terminal value.
        ia.load = 1'b1; ia.din = 4'd15;
        tick();
        chk("clamp_out", 32'(ia.out), 32'd9);
        chk("clamp_ovf", 32'(ia.ovf), 32'd0);
        ia.din = 4'd4; ia.ce = 1'b1; ia.up = 1'b1;
        #1;
        chk("ldce_tc", 32'(ia.tc), 32'd0);
        tick();
        chk("ldce_out", 32'(ia.out), 32'd4);
        chk("ldce_ovf", 32'(ia.ovf), 32'd0);

        // Down wrap in wrap mode, then direction flip at the top.
        ia.din = 4'd0;
        tick();
        ia.load = 1'b0; ia.up = 1'b0;
        #1;
        chk("dwrap_tc", 32'(ia.tc), 32'd1);
        tick();
        chk("dwrap_out", 32'(ia.out), 32'd9);
        chk("dwrap_ovf", 32'(ia.ovf), 32'd1);
        ia.up = 1'b1;
        #1;
        chk("flip_tc", 32'(ia.tc), 32'd1);
        tick();
        chk("flip_out", 32'(ia.out), 32'd0);
        chk("flip_ovf", 32'(ia.ovf), 32'd1);
        ia.ce = 1'b0;

        // Saturating down-count from 2.
        ib.load = 1'b1; ib.din = 4'd2;
        tick();
        chk("sat_load", 32'(ib.out), 32'd2);
        ib.load = 1'b0; ib.up = 1'b0; ib.ce = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            chk("sat_tc", 32'(ib.tc), 32'((i >= 3) ? 1 : 0));
            tick();
            chk("sat_out", 32'(ib.out), 32'((i == 1) ? 1 : 0));
            chk("sat_ovf", 32'(ib.ovf), 32'((i >= 3) ? 1 : 0));
        end
        ib.up = 1'b1;
        tick();
        chk("sat_inc", 32'(ib.out), 32'd1);
        ib.load = 1'b1; ib.din = 4'd9; ib.ce = 1'b0;
        tick();
        chk("sat_top_ovfclr", 32'(ib.ovf), 32'd0);
        ib.load = 1'b0; ib.ce = 1'b1;
        #1;
        chk("sat_top_tc", 32'(ib.tc), 32'd1);
        tick();
        chk("sat_top_out", 32'(ib.out), 32'd9);
        chk("sat_top_ovf", 32'(ib.ovf), 32'd1);
        ib.ce = 1'b0;

        // Two-stage decimal cascade: 00 -> 99 -> 00.
        ic1.ce = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("casc", 32'({ic2.out, ic1.out}), 32'((((i / 10) % 10) * 16) + (i % 10)));
        end
        ic1.ce = 1'b0;
        chk("casc_ovf1", 32'(ic1.ovf), 32'd1);
        chk("casc_ovf2", 32'(ic2.ovf), 32'd1);

        // Full 8-bit range: underflow 0 -> 255, then toggle direction.
        id.ce = 1'b1; id.up = 1'b0;
        #1;
        chk("bin_tc0", 32'(id.tc), 32'd1);
        tick();
        chk("bin_under", 32'(id.out), 32'd255);
        chk("bin_ovf", 32'(id.ovf), 32'd1);
        for (int i = 0; i < 6; i++) begin
            id.up = ((i % 2) == 0) ? 1'b1 : 1'b0;
            #1;
            chk("bin_tgl_tc", 32'(id.tc), 32'd1);
            tick();
            chk("bin_tgl_out", 32'(id.out), 32'(((i % 2) == 0) ? 0 : 255));
            chk("bin_tgl_ovf", 32'(id.ovf), 32'd1);
        end
        id.ce = 1'b0;

        // Reset wins over load and clears sticky flags mid-operation.
        rst = 1'b1; ia.load = 1'b1; ia.din = 4'd7; ia.ce = 1'b1;
        tick();
        chk("rstld_out", 32'(ia.out), 32'd3);
        chk("rstld_ovf", 32'(ia.ovf), 32'd0);
        chk("rstmid_d_ovf", 32'(id.ovf), 32'd0);
        rst = 1'b0; ia.load = 1'b0; ia.ce = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cntr_mod.md
# cntr_mod

Parametrised synchronous modulo counter: the general-purpose successor to the fixed 4-bit up-counter. It adds configurable width and modulus, up/down direction, parallel load, wrap or saturate mode, a combinational terminal-count output for cascading stages, and a sticky overflow flag. It is used wherever a timebase, divider or event counter is needed, and is chained through `tc` for wide counts.

## Interface

**Parameters**
- `WIDTH`, default 8: counter width in bits, ≥1.
- `MOD_VAL`, default 256: modulus; count range is 0..MOD_VAL-1. Legal range is 2..2^WIDTH.
- `SATURATE`, default 0: overflow behaviour.
  - 0: wrap.
  - 1: hold at the end value.
- `RST_VAL`, default 0: reset count; must be < MOD_VAL.

**Ports**
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `ce`  in  1: count enable.
- `up`  in  1: direction.
  - 1: increment.
  - 0: decrement.
- `load`  in  1: parallel load strobe.
- `din`  in  WIDTH: load value.
- `out`  out  WIDTH: current count, registered.
- `tc`  out  1: terminal count, combinational; used as the carry/borrow into the next stage's `ce`.
- `ovf`  out  1: sticky overflow/underflow flag, registered.

## Operation

**Priority per edge:** `rst` > `load` > `ce`.

- **`rst`=1:**
  - `out` <= RST_VAL.
  - `ovf` <= 0.
- **`load`=1:**
  - `out` <= `din` if `din` < MOD_VAL; otherwise `out` <= MOD_VAL-1 (clamp).
  - `ovf` <= 0.
  - `ce` and `up` are ignored that cycle.
- **`ce`=1, `up`=1:**
  - `out` < MOD_VAL-1: `out` <= `out`+1.
  - `out` = MOD_VAL-1, SATURATE=0: `out` <= 0 and `ovf` <= 1.
  - `out` = MOD_VAL-1, SATURATE=1: `out` holds and `ovf` <= 1.
- **`ce`=1, `up`=0:**
  - `out` > 0: `out` <= `out`-1.
  - `out` = 0, SATURATE=0: `out` <= MOD_VAL-1 and `ovf` <= 1.
  - `out` = 0, SATURATE=1: `out` holds and `ovf` <= 1.
- **`ce`=0:** `out` and `ovf` hold.

**`tc`**
- `tc` = `ce` & ~`load` & ~`rst` & (`up` ? `out`==MOD_VAL-1 : `out`==0).
- `tc` is asserted in both modes. A downstream stage enabled by `tc` therefore advances exactly on the edge where this stage wraps or sticks at its end.

**`ovf`**
- Once set, `ovf` stays set until `rst` or `load`.
- An overflow edge and a set `ovf` together leave `ovf` at 1.

**Arithmetic**
- Increment and decrement are computed at WIDTH+1 bits so there is no silent truncation.
- When MOD_VAL = 2^WIDTH, the compare against MOD_VAL-1 equals all-ones. Natural binary wrap is the required result.

**Direction changes**
- `up` may change on any cycle. Each edge uses the `up` value sampled at that edge.
- No internal direction state exists.

## Timing

- **Registered outputs:** `out` and `ovf` update one edge after the qualifying inputs are sampled. Latency from `ce`, `load` or `rst` to `out` is 1 cycle.
- **Combinational output:** `tc` has zero latency from `ce`, `up`, `load`, `rst` and `out`. The cascade path is one compare plus an AND; no registers are inserted.
- **Reset values:**
  - `out` = RST_VAL.
  - `ovf` = 0.
  - `tc` = 0 while `rst` is high.
- **Reset mid-operation:** reset takes effect on the next edge regardless of `ce`/`load`. No partial count survives.
- **Simultaneous events:**
  - `load` with `ce` at a terminal value: the load wins, `ovf` is cleared and `tc` = 0.
  - `rst` with `load`: the reset wins.
- **Throughput:** one count per cycle while `ce`=1 continuously.
- **Wrap period:** the wrap period in wrap mode is exactly MOD_VAL enabled cycles.

## Test plan

1. **Reset:** WIDTH=4, MOD_VAL=10, RST_VAL=3. Assert `rst` for 1 cycle with `ce`=1 → `out`=3 and `ovf`=0 on the next edge; `tc`=0 during reset.
2. **Up-count wrap:** same config, load 0, then `ce`=1, `up`=1 for 12 cycles →
   - `out` sequence 1..9, 0, 1, 2.
   - `tc`=1 only in the cycle where `out`=9.
   - `ovf` rises on the edge where `out` goes 9→0 and stays set.
3. **Down-count saturate:** SATURATE=1, MOD_VAL=10, load 2, `up`=0, `ce`=1 for 5 cycles → `out` = 1, 0, 0, 0, 0; `ovf`=1 from the third edge; `tc`=1 while `out`=0 and `ce`=1.
4. **Load priority and clamp:**
   - Load `din`=15 with MOD_VAL=10 → `out`=9.
   - Then assert `load`(`din`=4) together with `ce`=1, `up`=1 → `out`=4, `ovf`=0, `tc`=0 that cycle.
5. **Cascade:** two WIDTH=4, MOD_VAL=10 instances, with stage-2 `ce` = stage-1 `tc`. Run 100 enabled cycles from 0 → the pair reads 00→99 as decimal, then 00; stage 2 advances exactly once per stage-1 wrap.
6. **Full binary range:** WIDTH=8, MOD_VAL=256, `up`=0 from 0 → `out`=255 and `ovf`=1; direction is toggled every cycle thereafter → `out` alternates 0 ↔ 255 with no glitch values.
